// File: rtl/bpfcap_pkg.sv
// bpfcap_pkg: shared types and register-bank status bit positions for the capture path.
package bpfcap_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE
    } sched_state_t;

    typedef struct packed {
        logic [31:0] begin_addr;
        logic [31:0] end_addr;
    } desc_t;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_LEVEL_LSB = 1;

endpackage

// File: rtl/pkt_sched_if.sv
// pkt_sched_if: descriptor push handshake plus copy-engine launch/done signals.
interface pkt_sched_if;

    logic        desc_valid;
    logic [31:0] desc_begin;
    logic [31:0] desc_end;
    logic        desc_ready;
    logic        start;
    logic [31:0] cur_begin;
    logic [31:0] cur_end;
    logic [31:0] cur_wr_addr;
    logic        rd_done;
    logic        wr_done;

    modport master (
        input  desc_valid, desc_begin, desc_end, rd_done, wr_done,
        output desc_ready, start, cur_begin, cur_end, cur_wr_addr
    );

    modport slave (
        output desc_valid, desc_begin, desc_end, rd_done, wr_done,
        input  desc_ready, start, cur_begin, cur_end, cur_wr_addr
    );

endinterface

// File: rtl/pkt_sched_fifo.sv
// desc_fifo: show-ahead descriptor FIFO; a push into a full queue is taken when a pop happens in the same cycle.
module desc_fifo
    import bpfcap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  desc_t                  din,
    output desc_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    desc_t         mem_q [DEPTH];
    logic [AW:0]   wp_q;
    logic [AW:0]   rp_q;
    logic          do_push;
    logic          do_pop;

    assign level   = wp_q - rp_q;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pkt_sched.sv
// pkt_sched: launches one packet copy at a time and places packets contiguously in a circular capture buffer.
module pkt_sched
    import bpfcap_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535,
    parameter int CW      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [31:0]            wr_base,
    input  logic [31:0]            buf_size,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic [CW-1:0]          pkt_count,
    output logic [CW-1:0]          drop_count,
    output logic [CW-1:0]          err_count,
    pkt_sched_if.master            bus
);

    sched_state_t  state_q;
    logic          start_q;
    logic          rd_seen_q;
    logic          wr_seen_q;
    logic [31:0]   cur_begin_q;
    logic [31:0]   cur_end_q;
    logic [31:0]   cur_wr_addr_q;
    logic [31:0]   off_q;
    logic [31:0]   len_q;
    logic [31:0]   bsz_q;
    logic [31:0]   cnt_q;
    logic [CW-1:0] pkt_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] err_q;
    desc_t         head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic          invalid;
    logic [31:0]   len_in;
    logic [31:0]   hlen;
    logic [31:0]   load_off_d;
    logic [31:0]   off_sum;
    logic [31:0]   adv_off_d;
    logic          rd_n;
    logic          wr_n;
    logic          tmo;

    desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({bus.desc_begin, bus.desc_end}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // LOAD pops, so a full queue can still accept a descriptor in that cycle
    assign pop            = state_q == S_LOAD;
    assign bus.desc_ready = !full || pop;
    assign len_in         = bus.desc_end - bus.desc_begin;
    assign invalid        = bus.desc_end <= bus.desc_begin
                            || |(bus.desc_begin[1:0] | bus.desc_end[1:0])
                            || len_in > buf_size;
    assign push           = bus.desc_valid && bus.desc_ready && !invalid;
    assign drop           = bus.desc_valid && (!bus.desc_ready || invalid);
    assign hlen           = head.end_addr - head.begin_addr;
    // packets never straddle the buffer end: restart at offset 0 instead
    assign load_off_d     = ({1'b0, off_q} + {1'b0, hlen} > {1'b0, buf_size}) ? '0 : off_q;
    assign off_sum        = off_q + len_q;
    assign adv_off_d      = off_sum == bsz_q ? '0 : off_sum;
    assign rd_n           = rd_seen_q || bus.rd_done;
    assign wr_n           = wr_seen_q || bus.wr_done;
    assign tmo            = TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1);

    assign busy            = state_q != S_IDLE;
    assign bus.start       = start_q;
    assign bus.cur_begin   = cur_begin_q;
    assign bus.cur_end     = cur_end_q;
    assign bus.cur_wr_addr = cur_wr_addr_q;
    assign pkt_count       = pkt_q;
    assign drop_count      = drop_q;
    assign err_count       = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            rd_seen_q     <= 1'b0;
            wr_seen_q     <= 1'b0;
            cur_begin_q   <= '0;
            cur_end_q     <= '0;
            cur_wr_addr_q <= '0;
            off_q         <= '0;
            len_q         <= '0;
            bsz_q         <= '0;
            cnt_q         <= '0;
            pkt_q         <= '0;
            drop_q        <= '0;
            err_q         <= '0;
        end else begin
            start_q <= 1'b0;
            if (drop) drop_q <= drop_q + CW'(drop_q != '1);
            case (state_q)
                S_IDLE: if (enable && !empty) state_q <= S_LOAD;
                S_LOAD: begin
                    cur_begin_q   <= head.begin_addr;
                    cur_end_q     <= head.end_addr;
                    cur_wr_addr_q <= wr_base + load_off_d;
                    off_q         <= load_off_d;
                    len_q         <= hlen;
                    bsz_q         <= buf_size;
                    start_q       <= 1'b1;
                    state_q       <= S_ISSUE;
                end
                S_ISSUE: begin
                    rd_seen_q <= 1'b0;
                    wr_seen_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    rd_seen_q <= rd_n;
                    wr_seen_q <= wr_n;
                    cnt_q     <= cnt_q + 1'b1;
                    if (rd_n && wr_n) begin
                        state_q <= S_ADVANCE;
                    end else if (tmo) begin
                        err_q   <= err_q + CW'(err_q != '1);
                        state_q <= S_IDLE;
                    end
                end
                S_ADVANCE: begin
                    off_q   <= adv_off_d;
                    pkt_q   <= pkt_q + CW'(pkt_q != '1);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pkt_sched.md
Name: pkt_sched

Overview:
Packet-copy scheduler that sequences the read/write copy engines of the capture path.
- Queues packet descriptors (source begin/end byte addresses) written by the host into a small FIFO.
- Launches one copy at a time with a start pulse, then waits for both engines to report done.
- Places each packet contiguously in a circular capture buffer in HPS memory, and keeps packet, drop and error statistics readable through the register bank.

Parameters:
DEPTH, 8, descriptor queue entries; power of 2, ≥2
TIMEOUT, 65535, max cycles in WAIT before abort; 0 disables watchdog
CW, 16, width of statistics counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  allow launching new copies
desc_valid  in  1  push descriptor (single-cycle qualifier)
desc_begin  in  32  packet source start byte address (inclusive)
desc_end  in  32  packet source end byte address (exclusive)
desc_ready  out  1  queue not full
wr_base  in  32  capture buffer base address (word aligned)
buf_size  in  32  capture buffer size in bytes (word multiple, nonzero)
start  out  1  one-cycle launch pulse to both copy engines
cur_begin  out  32  source begin of active copy
cur_end  out  32  source end of active copy
cur_wr_addr  out  32  destination address of active copy
rd_done  in  1  read engine finished (pulse)
wr_done  in  1  write engine finished (pulse)
busy  out  1  FSM not in IDLE
level  out  $clog2(DEPTH)+1  queued descriptors
pkt_count  out  CW  completed copies, saturating
drop_count  out  CW  rejected descriptors, saturating
err_count  out  CW  watchdog aborts, saturating

Behaviour:
- Reset (sync, high): FSM=IDLE, queue empty, write offset=0, all counters 0. Outputs: start=0, busy=0, level=0, desc_ready=1, cur_*=0. Any copy in flight is abandoned; done pulses arriving afterwards are ignored.
- Push rules:
  - Push is accepted iff desc_valid && desc_ready.
  - Descriptor is invalid if desc_end ≤ desc_begin, or (desc_begin|desc_end)[1:0] ≠ 0, or len = desc_end−desc_begin > buf_size.
  - Invalid descriptors are not stored; drop_count increments.
  - desc_valid while full also increments drop_count.
  - Push and pop in the same cycle are both honoured, so level is unchanged; this applies when full too.
- FSM states: IDLE, LOAD, ISSUE, WAIT, ADVANCE.
  - IDLE→LOAD when enable && level>0.
  - LOAD: pop head into cur_begin/cur_end; compute len. If offset+len > buf_size, set offset=0 (wrap; packets never split). Set cur_wr_addr = wr_base+offset.
  - LOAD→ISSUE unconditionally. ISSUE: start=1 for exactly one cycle; clear rd_seen/wr_seen; →WAIT.
  - WAIT: latch rd_done→rd_seen and wr_done→wr_seen; pulses may arrive in any order or in the same cycle. When both are seen →ADVANCE.
  - WAIT timeout: if TIMEOUT≠0 and the wait counter reaches TIMEOUT, increment err_count; offset is unchanged; →IDLE.
  - ADVANCE: offset += len; if offset == buf_size then offset=0; pkt_count++; →IDLE.
- Latency: with the FSM in IDLE, enable=1 and an empty queue, a push in cycle t gives start in cycle t+3. That is level=1 at t+1, LOAD at t+2, ISSUE at t+3. Back-to-back copies are separated by ADVANCE, IDLE and LOAD.
- cur_* are held stable from ISSUE until the next LOAD.
- enable is sampled only in IDLE; deasserting it mid-copy lets the copy complete.
- Done pulses outside WAIT are ignored.
- Counters saturate at all-ones.
- wr_base and buf_size are sampled in LOAD; changing them mid-copy affects only later packets.

Decomposition:
- Shared package bpfcap_pkg: sched_state_t enum, desc_t struct {begin,end}, status-bit constants for register-bank readback (busy, level).
- One sub-module: desc_fifo, a DEPTH×64 synchronous FIFO with show-ahead head, full/empty/level and simultaneous push/pop support.
- FSM, offset arithmetic and counters stay in pkt_sched.

Test Plan:
- Push {0x1000,0x1040}, wr_base=0x8000_0000, buf_size=0x100, enable=1 → start at t+3; cur_wr_addr=0x8000_0000. After rd_done then wr_done, pkt_count=1 and the next packet lands at 0x8000_0040.
- Push lengths 0xC0 then 0x80, buf_size=0x100 → second cur_wr_addr=wr_base+0 (wrap); offset ends at 0x80.
- Fill 8 descriptors with enable=0 → desc_ready=0, level=8; a 9th push gives drop_count=1. Push and pop in the same cycle when full → level stays 8.
- Push end=begin, an unaligned begin=0x1002, and len=0x200>buf_size → drop_count=3, level=0, no start.
- TIMEOUT=16, no done pulses → err_count=1 at 16 cycles after WAIT entry, FSM returns to IDLE. A late wr_done does not change pkt_count.
- Assert reset during WAIT with 3 queued descriptors → next cycle level=0, busy=0, start=0, counters 0; subsequent rd_done ignored.
